// File: rtl/seg7_pkg.sv
`default_nettype none
//==============================================================================
// Module      : seg7_pkg
// Description : Shared constants and helpers for the seven-segment scan driver.
//               Segment patterns are active-low, ordered {g,f,e,d,c,b,a}.
// Contents    : SEG7_HEX[0:15] hex glyph table, SEG7_OFF all-dark pattern,
//               seg7_decode() nibble-to-glyph lookup.
// Revision    : 1.0 - initial release
//==============================================================================
package seg7_pkg;

    localparam logic [6:0] SEG7_OFF = 7'h7F;

    localparam logic [6:0] SEG7_HEX [0:15] = '{
        7'b1000000,  // 0
        7'b1111001,  // 1
        7'b0100100,  // 2
        7'b0110000,  // 3
        7'b0011001,  // 4
        7'b0010010,  // 5
        7'b0000010,  // 6
        7'b1111000,  // 7
        7'b0000000,  // 8
        7'b0010000,  // 9
        7'b0001000,  // A
        7'b0000011,  // b
        7'b1000110,  // C
        7'b0100001,  // d
        7'b0000110,  // E
        7'b0001110   // F
    };

    function automatic logic [6:0] seg7_decode(input logic [3:0] nibble);
        return SEG7_HEX[nibble];
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_scan_timer.sv
`default_nettype none
//==============================================================================
// Module      : seg7_scan_timer
// Description : Slot timing for the multiplexed display. A prescaler counts
//               0..SCAN_DIV-1 per digit slot; the slot index advances on each
//               prescaler wrap and returns to 0 after the last digit.
// Ports       : clk_i         - system clock
//               rst_ni        - synchronous reset, active-low
//               idx_o         - current slot (digit) index
//               in_blank_o    - high during the ghost-suppression window
//               frame_wrap_o  - high in the cycle the slot index returns to 0
//               frame_start_o - registered pulse aligned with the first pin
//                               cycle of slot 0
// Revision    : 1.0 - initial release
//==============================================================================
module seg7_scan_timer #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 50000,
    parameter int BLANK_CYC  = 500,
    parameter int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    output logic [IDX_W-1:0] idx_o,
    output logic             in_blank_o,
    output logic             frame_wrap_o,
    output logic             frame_start_o
);

    localparam int CNT_W = $clog2(SCAN_DIV);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             frame_start_q, frame_start_d;
    logic             slot_wrap;

    assign slot_wrap = (cnt_q == CNT_W'(SCAN_DIV - 1));

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        idx_d = idx_q;
        if (slot_wrap) begin
            cnt_d = '0;
            if (idx_q == IDX_W'(NUM_DIGITS - 1)) begin
                idx_d = '0;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end
        // Registered alongside the pin registers so the pulse lines up with
        // the first pin cycle of slot 0 (including the first frame after reset).
        frame_start_d = (cnt_q == '0) && (idx_q == '0);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q         <= '0;
            idx_q         <= '0;
            frame_start_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            frame_start_q <= frame_start_d;
        end
    end

    generate
        if (BLANK_CYC == 0) begin : g_no_blank
            assign in_blank_o = 1'b0;
        end else begin : g_blank
            assign in_blank_o = (cnt_q < CNT_W'(BLANK_CYC));
        end
    endgenerate

    assign idx_o         = idx_q;
    assign frame_wrap_o  = slot_wrap && (idx_q == IDX_W'(NUM_DIGITS - 1));
    assign frame_start_o = frame_start_q;

endmodule
`default_nettype wire

// File: rtl/seg7_scan_driver.sv
`default_nettype none
//==============================================================================
// Module      : seg7_scan_driver
// Description : Multi-digit seven-segment driver for a common-anode display on
//               a shared active-low segment bus. Captures value/masks into a
//               shadow buffer and swaps them into the displayed set only at a
//               frame boundary, so a frame never shows a mix of old and new.
// Ports       : clk_i, rst_ni       - clock, synchronous active-low reset
//               value_i             - nibble i drives digit i (0 = rightmost)
//               dp_mask_i           - decimal point per digit
//               blank_mask_i        - force digit dark
//               value_valid_i       - 1-cycle capture strobe
//               seg_n_o, dp_n_o     - active-low segments / decimal point
//               dig_en_n_o          - active-low digit enables (one-cold)
//               frame_start_o       - pulse on first pin cycle of slot 0
// Options     : SEG7_LEADING_BLANK_EN - blank digits above the most
//               significant non-zero nibble (dp bits hold digits lit).
// Revision    : 1.0 - initial release
//==============================================================================
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 50000,
    parameter int BLANK_CYC  = 500
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [4*NUM_DIGITS-1:0] value_i,
    input  logic [NUM_DIGITS-1:0]   dp_mask_i,
    input  logic [NUM_DIGITS-1:0]   blank_mask_i,
    input  logic                    value_valid_i,
    output logic [6:0]              seg_n_o,
    output logic                    dp_n_o,
    output logic [NUM_DIGITS-1:0]   dig_en_n_o,
    output logic                    frame_start_o
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [IDX_W-1:0] idx;
    logic             in_blank;
    logic             frame_wrap;

    seg7_scan_timer #(
        .NUM_DIGITS (NUM_DIGITS),
        .SCAN_DIV   (SCAN_DIV),
        .BLANK_CYC  (BLANK_CYC),
        .IDX_W      (IDX_W)
    ) u_timer (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .idx_o         (idx),
        .in_blank_o    (in_blank),
        .frame_wrap_o  (frame_wrap),
        .frame_start_o (frame_start_o)
    );

    // ---------------- double buffer ----------------
    logic [4*NUM_DIGITS-1:0] shadow_val_q, shadow_val_d, active_val_q, active_val_d;
    logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d, active_dp_q, active_dp_d;
    logic [NUM_DIGITS-1:0]   shadow_bl_q, shadow_bl_d, active_bl_q, active_bl_d;
    logic                    pending_q, pending_d;

    always_comb begin
        shadow_val_d = shadow_val_q;
        shadow_dp_d  = shadow_dp_q;
        shadow_bl_d  = shadow_bl_q;
        active_val_d = active_val_q;
        active_dp_d  = active_dp_q;
        active_bl_d  = active_bl_q;
        pending_d    = pending_q;
        if (value_valid_i) begin
            shadow_val_d = value_i;
            shadow_dp_d  = dp_mask_i;
            shadow_bl_d  = blank_mask_i;
        end
        if (frame_wrap) begin
            // A strobe coinciding with the wrap is newer than the shadow copy,
            // so it bypasses straight to the displayed set.
            if (value_valid_i) begin
                active_val_d = value_i;
                active_dp_d  = dp_mask_i;
                active_bl_d  = blank_mask_i;
            end else if (pending_q) begin
                active_val_d = shadow_val_q;
                active_dp_d  = shadow_dp_q;
                active_bl_d  = shadow_bl_q;
            end
            pending_d = 1'b0;
        end else if (value_valid_i) begin
            pending_d = 1'b1;
        end
    end

    // ---------------- automatic leading-zero blanking ----------------
    logic [NUM_DIGITS-1:0] lead_dark;

`ifdef SEG7_LEADING_BLANK_EN
    always_comb begin
        logic keep;
        keep      = 1'b0;
        lead_dark = '0;
        // Walk from the top digit down; once a non-zero nibble or a dp bit is
        // seen, that digit and everything below stays lit. Digit 0 always lit.
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            keep         = keep | (active_val_q[4*i +: 4] != 4'h0) | active_dp_q[i] | (i == 0);
            lead_dark[i] = ~keep;
        end
    end
`else
    assign lead_dark = '0;
`endif

    // ---------------- slot selection and output registers ----------------
    logic [3:0]            slot_nib;
    logic                  slot_dp;
    logic                  slot_dark;
    logic                  slot_en;
    logic [6:0]            seg_n_q, seg_n_d;
    logic                  dp_n_q, dp_n_d;
    logic [NUM_DIGITS-1:0] dig_en_n_q, dig_en_n_d;

    always_comb begin
        slot_nib  = 4'h0;
        slot_dp   = 1'b0;
        slot_dark = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                slot_nib  = active_val_q[4*i +: 4];
                slot_dp   = active_dp_q[i];
                slot_dark = active_bl_q[i] | lead_dark[i];
            end
        end
        slot_en = ~in_blank & ~slot_dark;

        seg_n_d = slot_en ? seg7_decode(slot_nib) : SEG7_OFF;
        dp_n_d  = slot_en ? ~slot_dp : 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            dig_en_n_d[i] = ~(slot_en && (idx == IDX_W'(i)));
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            shadow_val_q <= '0;
            shadow_dp_q  <= '0;
            shadow_bl_q  <= '0;
            active_val_q <= '0;
            active_dp_q  <= '0;
            active_bl_q  <= '0;
            pending_q    <= 1'b0;
            seg_n_q      <= SEG7_OFF;
            dp_n_q       <= 1'b1;
            dig_en_n_q   <= '1;
        end else begin
            shadow_val_q <= shadow_val_d;
            shadow_dp_q  <= shadow_dp_d;
            shadow_bl_q  <= shadow_bl_d;
            active_val_q <= active_val_d;
            active_dp_q  <= active_dp_d;
            active_bl_q  <= active_bl_d;
            pending_q    <= pending_d;
            seg_n_q      <= seg_n_d;
            dp_n_q       <= dp_n_d;
            dig_en_n_q   <= dig_en_n_d;
        end
    end

    assign seg_n_o    = seg_n_q;
    assign dp_n_o     = dp_n_q;
    assign dig_en_n_o = dig_en_n_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
//==============================================================================
// Module      : tb_seg7_scan_driver
// Description : Self-checking bench for seg7_scan_driver (4 digits, 8-cycle
//               slots, 2-cycle blanking). A cycle-indexed reference model
//               predicts every pin each cycle from the display rules.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_seg7_scan_driver;

    localparam int N     = 4;
    localparam int DIV   = 8;
    localparam int BLK   = 2;
    localparam int FRAME = N * DIV;

    localparam logic [6:0] GLYPH [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    logic         clk = 1'b0;
    logic         rst_n;
    logic [15:0]  value;
    logic [3:0]   dp_mask, blank_mask;
    logic         value_valid;
    logic [6:0]   seg_n;
    logic         dp_n;
    logic [3:0]   dig_en_n;
    logic         frame_start;

    always #5 clk = ~clk;

    seg7_scan_driver #(
        .NUM_DIGITS (N),
        .SCAN_DIV   (DIV),
        .BLANK_CYC  (BLK)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .value_i       (value),
        .dp_mask_i     (dp_mask),
        .blank_mask_i  (blank_mask),
        .value_valid_i (value_valid),
        .seg_n_o       (seg_n),
        .dp_n_o        (dp_n),
        .dig_en_n_o    (dig_en_n),
        .frame_start_o (frame_start)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int t;  // cycles since reset release; slot = (t/DIV)%N, position = t%DIV

    // Reference model: the newest write, and what the current frame displays.
    logic [15:0] m_last_v, m_act_v;
    logic [3:0]  m_last_dp, m_act_dp, m_last_bl, m_act_bl;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, t);
        end
    endtask

    // Highest digit that must stay lit: top non-zero nibble or top dp bit.
    function automatic int top_lit(input logic [15:0] v, input logic [3:0] dp);
        int top;
        top = 0;
        for (int d = 0; d < N; d++)
            if (((v >> (4 * d)) & 16'hF) != 0 || dp[d]) top = d;
        return top;
    endfunction

    task automatic model_reset();
        t = 0;
        m_last_v = '0; m_act_v = '0;
        m_last_dp = '0; m_act_dp = '0;
        m_last_bl = '0; m_act_bl = '0;
    endtask

    // Drive one cycle of inputs, predict the pins after the edge, then compare.
    task automatic run_cycle(input logic vv, input logic [15:0] v,
                             input logic [3:0] d, input logic [3:0] b);
        int pos, slot;
        logic dark, en;
        logic [6:0] e_seg;
        logic [3:0] e_dig, nib;
        logic e_dp, e_fs;

        value = v; dp_mask = d; blank_mask = b; value_valid = vv;

        pos  = t % DIV;
        slot = (t / DIV) % N;
        nib  = 4'((m_act_v >> (4 * slot)) & 16'hF);
        dark = m_act_bl[slot];
`ifdef SEG7_LEADING_BLANK_EN
        if (slot > top_lit(m_act_v, m_act_dp)) dark = 1'b1;
`endif
        en    = (pos >= BLK) && !dark;
        e_seg = en ? GLYPH[nib] : 7'h7F;
        e_dig = en ? ~(4'b0001 << slot) : 4'hF;
        e_dp  = en ? ~m_act_dp[slot] : 1'b1;
        e_fs  = ((t % FRAME) == 0);

        if (vv) begin
            m_last_v = v; m_last_dp = d; m_last_bl = b;
        end
        if ((t % FRAME) == FRAME - 1) begin
            m_act_v = m_last_v; m_act_dp = m_last_dp; m_act_bl = m_last_bl;
        end

        @(posedge clk); #1;
        check("seg_n", 32'(seg_n), 32'(e_seg));
        check("dig_en_n", 32'(dig_en_n), 32'(e_dig));
        check("dp_n", 32'(dp_n), 32'(e_dp));
        check("frame_start", 32'(frame_start), 32'(e_fs));
        t++;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) run_cycle(1'b0, value, dp_mask, blank_mask);
    endtask

    task automatic goto_phase(input int ph);
        while ((t % FRAME) != ph) run_cycle(1'b0, value, dp_mask, blank_mask);
    endtask

    task automatic do_reset(input int cycles);
        rst_n = 1'b0; value_valid = 1'b0;
        for (int k = 0; k < cycles; k++) begin
            @(posedge clk); #1;
            check("rst_seg_n", 32'(seg_n), 32'h7F);
            check("rst_dig_en_n", 32'(dig_en_n), 32'hF);
            check("rst_dp_n", 32'(dp_n), 32'h1);
            check("rst_frame_start", 32'(frame_start), 32'h0);
        end
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        logic        vv;
        logic [15:0] rv;
        logic [3:0]  rd, rb;

        value = '0; dp_mask = '0; blank_mask = '0; value_valid = 1'b0;
        model_reset();

        // Reset and idle frames
        do_reset(3);
        idle(2 * FRAME);

        // Scan of a hex value
        run_cycle(1'b1, 16'h12AF, 4'h0, 4'h0);
        idle(2 * FRAME + 5);

        // Tearing: strobes in slot 2 and slot 3, only the last one shows
        goto_phase(2 * DIV + 3);
        run_cycle(1'b1, 16'h1111, 4'h0, 4'h0);
        goto_phase(3 * DIV + 4);
        run_cycle(1'b1, 16'h2222, 4'h0, 4'h0);
        idle(FRAME + 10);

        // Strobe on the wrap cycle itself
        goto_phase(FRAME - 1);
        run_cycle(1'b1, 16'h8888, 4'h0, 4'h0);
        idle(FRAME);

        // Masks
        run_cycle(1'b1, 16'h12AF, 4'b0100, 4'b0001);
        idle(2 * FRAME);

        // Leading-zero patterns (plain display without the option)
        run_cycle(1'b1, 16'h0050, 4'h0, 4'h0);
        idle(2 * FRAME);
        run_cycle(1'b1, 16'h0000, 4'h0, 4'h0);
        idle(2 * FRAME);
        run_cycle(1'b1, 16'h0003, 4'b0100, 4'h0);
        idle(2 * FRAME);

        // Reset mid-scan discards a pending update
        goto_phase(DIV + 5);
        run_cycle(1'b1, 16'hCDEF, 4'hF, 4'h0);
        idle(3);
        do_reset(2);
        idle(2 * FRAME);

        // Randomized traffic, with extra weight on strobes at the wrap
        for (int k = 0; k < 1500; k++) begin
            vv = ($urandom_range(0, 9) == 0) ||
                 (((t % FRAME) == FRAME - 1) && ($urandom_range(0, 2) == 0));
            rv = 16'($urandom) >> (4 * $urandom_range(0, 4));
            rd = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
            rb = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            run_cycle(vv, rv, rd, rb);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
